mem_client_port: RTL and testbench

Requester-side port for the DDR SDRAM controller: accepts memory requests from a user block via valid/ready, queues them, and presents them one at a time on the controller's DO_ACT / ADDRESS_REQ / WE / DATA_W strobe interface. It retires each request on COMMAND_LATCHED. For reads, it counts the fixed controller read latency, captures DATA_R and returns it as a one-cycle response. It sits between any memory client and the enter_state/outputs pair of the controller.

---
 rtl/mem_client_pkg.sv | 24 ++
 rtl/mem_client_fifo.sv | 59 +++++
 rtl/mem_client_port.sv | 136 +++++++++++++
 tb/tb_mem_client_port.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_client_pkg.sv
// Shared types and constants for the DDR requester port.
// Address layout is {row, bank, column}; the request entry keeps that split.
package mem_client_pkg;
  localparam int ROW_MSB     = 27;
  localparam int ROW_LSB     = 15;
  localparam int BANK_MSB    = 14;
  localparam int BANK_LSB    = 13;
  localparam int COL_MSB     = 12;
  localparam int ADDR_W      = 28;
  localparam int DATA_W_BITS = 32;
  localparam int RD_LAT_DEF  = 4;

  typedef struct packed {
    logic [ROW_MSB-ROW_LSB:0]   row;
    logic [BANK_MSB-BANK_LSB:0] bank;
    logic [COL_MSB:0]           col;
    logic                       we;
    logic [DATA_W_BITS-1:0]     wdata;
  } req_entry_t;

  function automatic logic [ADDR_W-1:0] entry_addr(req_entry_t e);
    return {e.row, e.bank, e.col};
  endfunction
endpackage

// File: rtl/mem_client_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two so
// the pointers wrap naturally.
module mem_client_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // push and pop together leave occupancy unchanged
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/mem_client_port.sv
// Requester port: queues user requests, presents them on the controller strobe
// interface, and returns read data RD_LAT cycles after accept. MEMCLIENT_TAG_EN adds read tags.
module mem_client_port
  import mem_client_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int TAG_W  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic [ADDR_W-1:0]      REQ_ADDR,
  input  logic                   REQ_WE,
  input  logic [DATA_W_BITS-1:0] REQ_WDATA,
`ifdef MEMCLIENT_TAG_EN
  input  logic [TAG_W-1:0]       REQ_TAG,
  output logic [TAG_W-1:0]       RSP_TAG,
`endif
  output logic                   DO_ACT,
  output logic [ADDR_W-1:0]      ADDRESS_REQ,
  output logic                   WE,
  output logic [DATA_W_BITS-1:0] DATA_W,
  input  logic                   COMMAND_LATCHED,
  input  logic [DATA_W_BITS-1:0] DATA_R,
  output logic                   RSP_VALID,
  output logic [DATA_W_BITS-1:0] RSP_DATA,
  output logic                   BUSY
);
`ifdef MEMCLIENT_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int TAG_BITS = TAG_EN ? TAG_W : 0;
  localparam int ENT_W    = $bits(req_entry_t) + TAG_BITS;

  req_entry_t       push_ent, head_ent;
  logic [ENT_W-1:0] fifo_wdata, fifo_rdata;
  logic             full, empty, push, pop, accept_rd;

  always_comb begin
    push_ent       = '0;
    push_ent.row   = REQ_ADDR[ROW_MSB:ROW_LSB];
    push_ent.bank  = REQ_ADDR[BANK_MSB:BANK_LSB];
    push_ent.col   = REQ_ADDR[COL_MSB:0];
    push_ent.we    = REQ_WE;
    push_ent.wdata = REQ_WDATA;
  end

`ifdef MEMCLIENT_TAG_EN
  logic [TAG_W-1:0] head_tag;
  assign fifo_wdata           = {REQ_TAG, push_ent};
  assign {head_tag, head_ent} = fifo_rdata;
`else
  assign fifo_wdata = push_ent;
  assign head_ent   = fifo_rdata;
`endif

  // Ready looks only at current occupancy, so a same-cycle pop never frees a slot.
  assign REQ_READY = !full && !RST;
  assign push      = REQ_VALID && REQ_READY;
  assign pop       = COMMAND_LATCHED && !empty;
  assign accept_rd = pop && !head_ent.we;

  mem_client_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  // Head fields are masked while empty so stale storage never leaks out.
  assign DO_ACT      = !empty;
  assign ADDRESS_REQ = empty ? '0 : entry_addr(head_ent);
  assign WE          = !empty && head_ent.we;
  assign DATA_W      = empty ? '0 : head_ent.wdata;

  logic [RD_LAT-1:0]      vld_pipe_q, vld_pipe_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W_BITS-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    for (int i = RD_LAT-1; i > 0; i--) vld_pipe_d[i] = vld_pipe_q[i-1];
    vld_pipe_d[0] = accept_rd;
    rsp_valid_d   = vld_pipe_q[RD_LAT-1];
    rsp_data_d    = vld_pipe_q[RD_LAT-1] ? DATA_R : rsp_data_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign BUSY      = !empty || (|vld_pipe_q);

`ifdef MEMCLIENT_TAG_EN
  // Tag travels alongside the valid bit; only meaningful where the bit is set.
  logic [RD_LAT-1:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;
  logic [TAG_W-1:0]             rsp_tag_q, rsp_tag_d;

  always_comb begin
    tag_pipe_d = tag_pipe_q;
    for (int i = RD_LAT-1; i > 0; i--) tag_pipe_d[i] = tag_pipe_q[i-1];
    tag_pipe_d[0] = head_tag;
    rsp_tag_d     = vld_pipe_q[RD_LAT-1] ? tag_pipe_q[RD_LAT-1] : rsp_tag_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_pipe_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      tag_pipe_q <= tag_pipe_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  assign RSP_TAG = rsp_tag_q;
`endif
endmodule

// File: tb/tb_mem_client_port.sv
// Scoreboard bench for mem_client_port: a queue-level model predicts presentation,
// flow control and read responses; a negedge monitor compares every cycle.
module tb_mem_client_port;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 4;
  localparam int TAG_W  = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             REQ_VALID = 1'b0;
  logic             REQ_WE = 1'b0;
  logic             COMMAND_LATCHED = 1'b0;
  logic [27:0]      REQ_ADDR = '0;
  logic [31:0]      REQ_WDATA = '0;
  logic [31:0]      DATA_R = '0;
  logic [TAG_W-1:0] REQ_TAG = '0;
  logic             REQ_READY, DO_ACT, WE, RSP_VALID, BUSY;
  logic [27:0]      ADDRESS_REQ;
  logic [31:0]      DATA_W, RSP_DATA;
`ifdef MEMCLIENT_TAG_EN
  logic [TAG_W-1:0] RSP_TAG;
`endif

  mem_client_port #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .TAG_W(TAG_W)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .REQ_VALID       (REQ_VALID),
    .REQ_READY       (REQ_READY),
    .REQ_ADDR        (REQ_ADDR),
    .REQ_WE          (REQ_WE),
    .REQ_WDATA       (REQ_WDATA),
`ifdef MEMCLIENT_TAG_EN
    .REQ_TAG         (REQ_TAG),
    .RSP_TAG         (RSP_TAG),
`endif
    .DO_ACT          (DO_ACT),
    .ADDRESS_REQ     (ADDRESS_REQ),
    .WE              (WE),
    .DATA_W          (DATA_W),
    .COMMAND_LATCHED (COMMAND_LATCHED),
    .DATA_R          (DATA_R),
    .RSP_VALID       (RSP_VALID),
    .RSP_DATA        (RSP_DATA),
    .BUSY            (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] dr_ovr [int];

  function automatic logic [31:0] dr_val(int c);
    if (dr_ovr.exists(c)) return dr_ovr[c];
    return (c * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // DATA_R in cycle c is a known function of c, so the model can predict it at accept time.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    #1 DATA_R = dr_val(cyc);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d wait bound expired", nm, cyc);
  endtask

  typedef struct { logic [27:0] addr; logic we; logic [31:0] wdata; logic [TAG_W-1:0] tag; } mreq_t;
  typedef struct { int due; logic [31:0] data; logic [TAG_W-1:0] tag; } mrsp_t;
  mreq_t mq[$];
  mrsp_t exq[$];
  mreq_t m_head;
  mrsp_t m_rsp;
  bit    m_busy, m_room;

  always @(negedge CLK) begin
    if (RST) begin
      mq.delete();
      exq.delete();
      chk("rst_req_ready", {31'b0, REQ_READY}, 0);
      chk("rst_do_act", {31'b0, DO_ACT}, 0);
      chk("rst_address_req", {4'b0, ADDRESS_REQ}, 0);
      chk("rst_we", {31'b0, WE}, 0);
      chk("rst_data_w", DATA_W, 0);
      chk("rst_rsp_valid", {31'b0, RSP_VALID}, 0);
      chk("rst_rsp_data", RSP_DATA, 0);
      chk("rst_busy", {31'b0, BUSY}, 0);
`ifdef MEMCLIENT_TAG_EN
      chk("rst_rsp_tag", {28'b0, RSP_TAG}, 0);
`endif
    end else begin
      m_busy = mq.size() > 0;
      foreach (exq[i]) if (exq[i].due > cyc) m_busy = 1'b1;
      chk("req_ready", {31'b0, REQ_READY}, {31'b0, mq.size() < DEPTH});
      chk("do_act", {31'b0, DO_ACT}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("address_req", {4'b0, ADDRESS_REQ}, {4'b0, mq[0].addr});
        chk("we", {31'b0, WE}, {31'b0, mq[0].we});
        chk("data_w", DATA_W, mq[0].wdata);
      end
      chk("busy", {31'b0, BUSY}, {31'b0, m_busy});
      if (exq.size() > 0 && exq[0].due == cyc) begin
        m_rsp = exq.pop_front();
        chk("rsp_valid", {31'b0, RSP_VALID}, 1);
        chk("rsp_data", RSP_DATA, m_rsp.data);
`ifdef MEMCLIENT_TAG_EN
        chk("rsp_tag", {28'b0, RSP_TAG}, {28'b0, m_rsp.tag});
`endif
      end else begin
        chk("rsp_valid_idle", {31'b0, RSP_VALID}, 0);
      end
      // advance the model across the coming edge
      m_room = mq.size() < DEPTH;
      if (COMMAND_LATCHED && mq.size() > 0) begin
        m_head = mq.pop_front();
        if (!m_head.we)
          exq.push_back('{due: cyc + RD_LAT + 1, data: dr_val(cyc + RD_LAT), tag: m_head.tag});
      end
      if (REQ_VALID && m_room)
        mq.push_back('{addr: REQ_ADDR, we: REQ_WE, wdata: REQ_WDATA, tag: REQ_TAG});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [27:0] a, input logic [31:0] d,
                          input logic [TAG_W-1:0] t);
    int n = 0;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = d; REQ_TAG = t;
    while (!REQ_READY) begin
      if (n++ > 50) begin timeout("push_wait"); break; end
      step();
    end
    step();
    REQ_VALID = 1'b0;
  endtask

  task automatic latch_rd(input logic [31:0] d);
    dr_ovr[cyc + RD_LAT] = d;
    COMMAND_LATCHED = 1'b1;
    step();
    COMMAND_LATCHED = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    idle(3);
    RST = 1'b0;
    idle(2);

    // single write, latched on the third presented cycle
    push_req(1'b1, 28'h0A55123, 32'hDEADBEEF, 4'd0);
    idle(2);
    COMMAND_LATCHED = 1'b1;
    step();
    COMMAND_LATCHED = 1'b0;
    idle(6);

    // single read with a known return value
    push_req(1'b0, 28'h0000040, 32'h0, 4'd5);
    idle(1);
    latch_rd(32'h12345678);
    idle(8);

    // four back-to-back reads
    for (int k = 0; k < 4; k++) push_req(1'b0, 28'(k * 16), 32'h0, 4'(k));
    for (int k = 0; k < 4; k++) begin
      dr_ovr[cyc + RD_LAT] = 32'(k + 1);
      COMMAND_LATCHED = 1'b1;
      step();
    end
    COMMAND_LATCHED = 1'b0;
    idle(8);

    // fill the queue, hold a fifth request that must be refused, then free one slot
    for (int k = 0; k < 4; k++) push_req(1'b1, 28'h1000 + 28'(k), 32'hA0 + 32'(k), 4'(k));
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 28'hFFFFFFF; REQ_WDATA = 32'hBAD0BAD0;
    idle(3);
    REQ_VALID = 1'b0;
    COMMAND_LATCHED = 1'b1;
    step();
    COMMAND_LATCHED = 1'b0;
    idle(2);
    COMMAND_LATCHED = 1'b1;
    idle(3);
    COMMAND_LATCHED = 1'b0;
    idle(2);

    // latch strobes with nothing queued
    COMMAND_LATCHED = 1'b1;
    idle(3);
    COMMAND_LATCHED = 1'b0;
    idle(2);

    // reset two cycles after a read accept, with another request still queued
    push_req(1'b0, 28'h0000080, 32'h0, 4'd9);
    push_req(1'b0, 28'h00000C0, 32'h0, 4'd10);
    latch_rd(32'hCAFEF00D);
    idle(1);
    RST = 1'b1;
    #1;
    chk("async_do_act", {31'b0, DO_ACT}, 0);
    chk("async_busy", {31'b0, BUSY}, 0);
    idle(2);
    RST = 1'b0;
    idle(8);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      REQ_VALID = ($urandom_range(0, 2) != 0);
      REQ_WE = $urandom_range(0, 1) == 1;
      REQ_ADDR = 28'($urandom);
      REQ_WDATA = $urandom;
      REQ_TAG = 4'($urandom);
      COMMAND_LATCHED = ($urandom_range(0, 2) == 0);
      step();
    end
    REQ_VALID = 1'b0;

    // drain
    COMMAND_LATCHED = 1'b1;
    n = 0;
    while (BUSY || exq.size() > 0) begin
      if (n++ > 200) begin timeout("drain"); break; end
      step();
    end
    COMMAND_LATCHED = 1'b0;
    idle(RD_LAT + 3);
    chk("final_pending", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
